// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: shared geometry, handshake sizing and FSM encoding for the expand-weight fetch path.
package ex_ctrl_pkg;
  localparam int DATA_WIDTH = 14;
  localparam int ROWS = 16;
  localparam int COLS = 16;
  localparam int ADDR_W = 10;
  localparam int EX_HEIGHT = 657;
  localparam int MEM_LAT = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int WORD_W = ROWS * COLS * DATA_WIDTH;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  typedef enum logic [2:0] {ST_IDLE, ST_CHECK, ST_FETCH, ST_DRAIN, ST_DONE} state_e;
endpackage

// File: rtl/ex_wt_fifo.sv
// ex_wt_fifo: synchronous FIFO with occupancy count and same-cycle push/pop.
module ex_wt_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic full, do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_push = push && (!full || pop);
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      wr <= do_push ? wr + AW'(1) : wr;
      rd <= do_pop ? rd + AW'(1) : rd;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ex_weight_fetch_ctrl.sv
// ex_weight_fetch_ctrl: replays a row range of the expand weight memory and streams rows to the PE array.
module ex_weight_fetch_ctrl
  import ex_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_idx,
  input  logic [ADDR_W-1:0] num_rows,
  input  logic [7:0]        num_passes,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_index,
  output logic              mem_en,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              w_last,
  output logic              w_pass_last
);
  state_e state;
  logic [ADDR_W-1:0] base_q, rows_q, row;
  logic [7:0] passes_q, pass;
  logic [MEM_LAT-1:0] tag_v, tag_l, tag_pl;
  logic [CNT_W-1:0] count;
  logic [7:0] inflight;
  logic empty, pop, issue, row_last, pass_last;
  logic [WORD_W+1:0] head;
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight += 8'(tag_v[i]);
  end
  assign pop = w_valid & w_ready;
  // A pop this cycle frees a slot in time for a read issued now.
  assign issue = (state == ST_FETCH) && (9'(count) + 9'(inflight) < 9'(FIFO_DEPTH) + 9'(pop));
  assign row_last = row == rows_q - ADDR_W'(1);
  assign pass_last = row_last && (pass == passes_q - 8'd1);
  assign mem_en = issue;
  assign mem_rd = issue;
  assign mem_wr = 1'b0;
  assign mem_index = issue ? base_q + row : '0;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  assign w_valid = !empty;
  assign w_data = w_valid ? head[WORD_W-1:0] : '0;
  assign w_last = w_valid & head[WORD_W];
  assign w_pass_last = w_valid & head[WORD_W+1];
  ex_wt_fifo #(.W(WORD_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_v[MEM_LAT-1]),
    .din   ({tag_pl[MEM_LAT-1], tag_l[MEM_LAT-1], mem_data}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      base_q <= '0;
      rows_q <= '0;
      passes_q <= '0;
      row <= '0;
      pass <= '0;
      err <= 1'b0;
      tag_v <= '0;
      tag_l <= '0;
      tag_pl <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_l[0] <= row_last;
      tag_pl[0] <= pass_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
        tag_pl[i] <= tag_pl[i-1];
      end
      case (state)
        ST_IDLE:
          if (start) begin
            base_q <= base_idx;
            rows_q <= num_rows;
            passes_q <= num_passes;
            row <= '0;
            pass <= '0;
            err <= 1'b0;
            state <= ST_CHECK;
          end
        ST_CHECK:
          if (rows_q == '0 || passes_q == '0) state <= ST_DONE;
          else if ({1'b0, base_q} + {1'b0, rows_q} > (ADDR_W + 1)'(EX_HEIGHT)) begin
            err <= 1'b1;
            state <= ST_DONE;
          end else state <= ST_FETCH;
        ST_FETCH:
          if (issue) begin
            row <= row_last ? '0 : row + ADDR_W'(1);
            pass <= row_last ? pass + 8'd1 : pass;
            state <= pass_last ? ST_DRAIN : ST_FETCH;
          end
        ST_DRAIN:
          if (inflight == '0 && empty) state <= ST_DONE;
        ST_DONE:
          state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ex_weight_fetch_ctrl.md
Name: ex_weight_fetch_ctrl

Overview:
Downstream read sequencer for the 1x1 expand weight memory (Memory_1x1_EX_bneck) of a bneck block. On a start command it walks a contiguous row range of that memory, once per spatial pass. Each wide row holds 16x16 weights of 14 bits. Returned rows are buffered in a small FIFO and streamed to the 1x1 PE array over a valid/ready handshake, so memory read latency is hidden and backpressure is absorbed.

Parameters:
DATA_WIDTH, 14, bits per weight
ROWS, 16, PE rows per memory word
COLS, 16, weights per PE row
HEIGHT, 657, memory depth in words
ADDR_W, 10, memory index width
MEM_LAT, 1, memory read latency in cycles (en/rd to valid data_out)
FIFO_DEPTH, 4, output buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle command pulse; ignored while busy
base_idx  in  ADDR_W  first memory row
num_rows  in  ADDR_W  rows per pass
num_passes  in  8  times the row range is replayed
busy  out  1  command in progress
done  out  1  one-cycle pulse after the final beat handshakes
err  out  1  sticky range error; cleared by next accepted start or rst
mem_index  out  ADDR_W  memory row address
mem_en  out  1  memory enable
mem_rd  out  1  memory read strobe
mem_wr  out  1  constant 0
mem_data  in  ROWS*COLS*DATA_WIDTH  memory data_out
w_data  out  ROWS*COLS*DATA_WIDTH  weight row to PE array (FIFO head)
w_valid  out  1  w_data valid
w_ready  in  1  PE array accepts
w_last  out  1  beat is the last row of a pass
w_pass_last  out  1  beat is the last row of the last pass

Behaviour:
- Reset values: all outputs 0, FSM IDLE, FIFO empty, in-flight pipe cleared, err 0. Reset mid-operation discards in-flight and buffered rows; no done pulse is generated.
- FSM states and transitions:
  - IDLE -> CHECK on start; the command is latched.
  - CHECK (1 cycle): if num_rows==0 or num_passes==0, go to DONE with no reads. If base_idx+num_rows > HEIGHT (computed at ADDR_W+1 bits), set err and go to DONE with no reads. Otherwise go to FETCH.
  - FETCH: issue reads; go to DRAIN after the final read is issued.
  - DRAIN: wait until in-flight==0, FIFO empty, and the final beat has handshaked; then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Read issue rule:
  - Issue (mem_en=mem_rd=1, mem_index=base_idx+row) only when FIFO_DEPTH - count - inflight + pop > 0, where pop = w_valid & w_ready this cycle.
  - mem_en=mem_rd=0 otherwise.
  - Addresses are held at 0 when not issuing.
- Order: pass p=0..num_passes-1; within each pass, row r=0..num_rows-1. r wraps to 0 and p increments at the end of a pass.
- Capture: a MEM_LAT-deep valid shift register tags each issue. mem_data is pushed into the FIFO on the cycle its tag emerges, together with its last and pass_last flags.
- Latency (MEM_LAT=1, FIFO empty, w_ready=1): start sampled at edge E0; CHECK occupies cycle E0-E1; first read is issued in cycle E1-E2; first w_valid is visible after E3.
- Throughput: 1 row/cycle is sustained while w_ready=1.
- Push and pop in the same cycle are legal when the FIFO is full or empty; the credit rule guarantees no overflow.
- Handshake: w_data, w_last and w_pass_last stay stable while w_valid=1 and w_ready=0.
- A start pulse while busy is ignored and leaves no side effect.

Decomposition:
- Shared package (ex_ctrl_pkg): DATA_WIDTH, ROWS, COLS, ADDR_W, EX_HEIGHT=657, derived WORD_W=ROWS*COLS*DATA_WIDTH, and the FSM state encoding.
- One natural sub-module: ex_wt_fifo, a synchronous FIFO of WORD_W+2 bits with count output and simultaneous push/pop support, reset by rst.

Test Plan:
- base_idx=0, num_rows=4, num_passes=1, w_ready=1:
  - mem_index sequence 0,1,2,3 on consecutive cycles.
  - 4 beats equal to memory rows 0-3; w_last and w_pass_last on beat 4.
  - done pulses exactly once; first w_valid appears 3 edges after start.
- base_idx=650, num_rows=7, num_passes=3:
  - 21 beats cycling rows 650..656.
  - w_last on beats 7, 14, 21; w_pass_last only on beat 21.
- base_idx=652, num_rows=6:
  - err=1, no mem_en assertion, done pulses 2 cycles after start.
  - The next valid start clears err.
- num_rows=0 or num_passes=0 -> no reads, no w_valid, done after 2 cycles.
- Random w_ready (50% duty), num_rows=20:
  - FIFO count never exceeds 4; w_data stable while stalled; all 20 rows arrive in order.
  - Also check a second start issued mid-run is ignored.
- Assert rst during FETCH with 3 rows buffered:
  - Next cycle w_valid=0, busy=0, mem_en=0, no done.
  - A new command afterwards runs correctly.
